// File: rtl/alu_operand_sequencer_pkg.sv
// Shared definitions for the ALU operand sequencer: FSM state encoding,
// ALU opcode constants and a small state-classification helper.
package alu_operand_sequencer_pkg;

  // Sequencer states: three load steps, one execute cycle, one hold phase.
  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    EXEC    = 3'd3,
    HOLD    = 3'd4
  } state_e;

  // ALU select encoding, shared with the ALU and its users.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_AND = 1'b1;

  // True in the states where an input word may be accepted.
  function automatic logic is_load_state(input state_e s);
    return (s == LOAD_A) || (s == LOAD_B) || (s == LOAD_OP);
  endfunction

endpackage

// File: rtl/alu_operand_sequencer.sv
// Operand sequencer in front of a W-bit combinational ALU.
// Collects operand A, operand B and the opcode as three words on a single
// valid/ready input bus, drives them into the ALU from registers, then
// captures the ALU result into a registered valid/ready output.
module alu_operand_sequencer
  import alu_operand_sequencer_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic         alu_sel,
  input  logic [W-1:0] alu_c,
  output logic [W-1:0] res_data,
  output logic         res_zero,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         busy
);

  state_e       state_q,     state_d;
  logic [W-1:0] alu_a_q,     alu_a_d;
  logic [W-1:0] alu_b_q,     alu_b_d;
  logic         alu_sel_q,   alu_sel_d;
  logic [W-1:0] res_data_q,  res_data_d;
  logic         res_zero_q,  res_zero_d;
  logic         res_valid_q, res_valid_d;

  logic in_hs;
  logic out_hs;

  // Input is only accepted in the load states, and never while reset is held
  // (state already reads LOAD_A during reset, so rst gates it explicitly).
  assign in_ready = !rst && is_load_state(state_q);
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = res_valid_q && res_ready;

  // Next-state and register-update logic; clr overrides any handshake.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    res_data_d  = res_data_q;
    res_zero_d  = res_zero_q;
    res_valid_d = res_valid_q;

    if (clr) begin
      // Abort: drop any partial load or pending result, keep operands.
      state_d     = LOAD_A;
      res_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        LOAD_A: begin
          if (in_hs) begin
            alu_a_d = in_data;
            state_d = LOAD_B;
          end
        end
        LOAD_B: begin
          if (in_hs) begin
            alu_b_d = in_data;
            state_d = LOAD_OP;
          end
        end
        LOAD_OP: begin
          if (in_hs) begin
            // Only bit 0 carries the opcode; upper bits are don't-care.
            alu_sel_d = in_data[0];
            state_d   = EXEC;
          end
        end
        EXEC: begin
          // ALU inputs have been stable for a full cycle; sample its result.
          res_data_d  = alu_c;
          res_zero_d  = (alu_c == '0);
          res_valid_d = 1'b1;
          state_d     = HOLD;
        end
        HOLD: begin
          if (out_hs) begin
            res_valid_d = 1'b0;
            state_d     = LOAD_A;
          end
        end
        default: begin
          state_d     = LOAD_A;
          res_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (rst) begin
      state_q     <= LOAD_A;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= OP_ADD;
      res_data_q  <= '0;
      res_zero_q  <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      res_data_q  <= res_data_d;
      res_zero_q  <= res_zero_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign res_data  = res_data_q;
  assign res_zero  = res_zero_q;
  assign res_valid = res_valid_q;
  assign busy      = (state_q != LOAD_A);

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Self-checking bench for alu_operand_sequencer. A behavioural ALU sits
// beside the DUT; a driver issues operations and queues expected results,
// and an independent monitor compares every result handshake.
module tb_alu_operand_sequencer;
  import alu_operand_sequencer_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         clr;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic         alu_sel;
  logic [W-1:0] alu_c;
  logic [W-1:0] res_data;
  logic         res_zero;
  logic         res_valid;
  logic         res_ready;
  logic         busy;

  alu_operand_sequencer #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_c     (alu_c),
    .res_data  (res_data),
    .res_zero  (res_zero),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the external combinational ALU.
  always_comb alu_c = (alu_sel == OP_AND) ? (alu_a & alu_b) : W'(alu_a + alu_b);

  typedef struct packed {
    logic [W-1:0] data;
    logic         zero;
  } res_t;

  res_t         exp_q[$];
  int           hs_cyc[$];
  int           compared   = 0;
  int           mismatched = 0;
  int           cyc        = 0;
  int           op_cyc     = 0;
  logic [W-1:0] last_a, last_b;
  logic         last_sel;
  bit           rand_rr    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every result handshake is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      res_t e;
      hs_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_result", res_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("res_data", res_data, e.data);
        check("res_zero", res_zero, e.zero);
      end
    end
  end

  // Drive one word after an optional random gap; return just after it is taken.
  task automatic send_word(input logic [W-1:0] w, input int max_gap);
    int gap;
    int waited;
    gap    = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
    waited = 0;
    repeat (gap) begin
      in_valid = 1'b0;
      in_data  = W'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = w;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 50) begin
        check("in_ready_timeout", in_ready, 1'b1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = W'($urandom);
  endtask

  // One full operation; expected result is computed from the rules directly.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] op, input int max_gap);
    res_t e;
    int   sum;
    send_word(a, max_gap);
    send_word(b, max_gap);
    send_word(op, max_gap);
    op_cyc   = cyc;
    last_a   = a;
    last_b   = b;
    last_sel = op[0];
    sum      = (int'(a) + int'(b)) % (1 << W);
    e.data   = op[0] ? (a & b) : W'(sum);
    e.zero   = (e.data == '0);
    exp_q.push_back(e);
  endtask

  task automatic wait_res_valid();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!res_valid && n < 50);
    if (!res_valid) check("res_valid_timeout", res_valid, 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] hold_data;
    logic         hold_zero;
    logic [W-1:0] ra, rb;

    rst       = 1'b1;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    res_ready = 1'b0;
    last_a    = '0;
    last_b    = '0;
    last_sel  = 1'b0;

    // Reset: no input handshake offered while rst is high.
    #2;
    check("rst_in_ready", in_ready, 1'b0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_sel", alu_sel, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_zero", res_zero, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("idle_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Wrapping add: 9 + 8 = 1, one-cycle result pulse, then ready again.
    res_ready = 1'b1;
    do_op(4'h9, 4'h8, 4'h0, 0);
    wait_res_valid();
    check("latency", cyc - op_cyc, 1);
    @(negedge clk);
    check("pulse_res_valid_low", res_valid, 1'b0);
    check("pulse_in_ready", in_ready, 1'b1);
    check("operand_a_kept", alu_a, 4'h9);
    check("operand_b_kept", alu_b, 4'h8);
    @(posedge clk);
    #1;

    // AND giving zero (op bit0 = 1, upper bits ignored), then add via op 4'hE.
    do_op(4'hC, 4'h3, 4'hF, 0);
    do_op(4'hC, 4'h3, 4'hE, 0);
    drain();

    // Back-pressure: result held stable for 6 cycles with in_ready low.
    res_ready = 1'b0;
    do_op(W'($urandom), W'($urandom), W'($urandom), 3);
    wait_res_valid();
    hold_data = exp_q[0].data;
    hold_zero = exp_q[0].zero;
    in_valid  = 1'b1;
    in_data   = W'($urandom);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("hold_res_data", res_data, hold_data);
      check("hold_res_zero", res_zero, hold_zero);
      check("hold_res_valid", res_valid, 1'b1);
      check("hold_in_ready", in_ready, 1'b0);
      check("hold_busy", busy, 1'b1);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_taken_first_cycle", res_valid, 1'b0);
    check("bp_idle", busy, 1'b0);
    @(posedge clk);
    #1;

    // clr in LOAD_OP with a valid opcode word: opcode must not be taken.
    ra = W'($urandom);
    rb = W'($urandom);
    send_word(ra, 0);
    send_word(rb, 0);
    in_valid = 1'b1;
    in_data  = {{(W-1){1'b1}}, ~last_sel};
    clr      = 1'b1;
    @(posedge clk);
    #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("clr_busy", busy, 1'b0);
    check("clr_in_ready", in_ready, 1'b1);
    check("clr_alu_sel_kept", alu_sel, last_sel);
    check("clr_alu_a", alu_a, ra);
    check("clr_alu_b", alu_b, rb);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("clr_no_result", res_valid, 1'b0);
    end
    @(posedge clk);
    #1;

    // Asynchronous reset mid-HOLD, between clock edges.
    res_ready = 1'b0;
    do_op(4'h7, 4'h5, 4'h0, 1);
    wait_res_valid();
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("arst_res_valid", res_valid, 0);
    check("arst_res_data", res_data, 0);
    check("arst_res_zero", res_zero, 0);
    check("arst_alu_a", alu_a, 0);
    check("arst_alu_b", alu_b, 0);
    check("arst_alu_sel", alu_sel, 0);
    check("arst_busy", busy, 0);
    check("arst_in_ready", in_ready, 0);
    @(negedge clk);
    #1;
    rst       = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    do_op(4'hA, 4'h6, 4'h2, 0);
    drain();

    // Back-to-back: one result every 5 cycles.
    hs_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      do_op(W'($urandom), W'($urandom), W'(i), 0);
    end
    drain();
    check("b2b_result_count", hs_cyc.size(), 8);
    for (int i = 1; i < hs_cyc.size(); i++) begin
      check("b2b_period", hs_cyc[i] - hs_cyc[i-1], 5);
    end

    // Random operations with input gaps and random consumer back-pressure.
    rand_rr = 1'b1;
    fork
      begin
        while (rand_rr) begin
          @(posedge clk);
          #1;
          res_ready = ($urandom_range(3, 0) != 0);
        end
      end
    join_none
    for (int i = 0; i < 20; i++) begin
      do_op(W'($urandom), W'($urandom), W'($urandom), 3);
    end
    rand_rr = 1'b0;
    @(posedge clk);
    #2;
    res_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_operand_sequencer.md
Name: alu_operand_sequencer

Overview:
Upstream/downstream wrapper around the 4-bit combinational ALU (add / bitwise AND selected by a 1-bit select). Accepts operand A, operand B and the opcode one per word over a single W-bit valid/ready input bus, holds them in registers driving the ALU inputs, then captures the ALU result into a result register offered on a valid/ready output. Lets a narrow input port (switches, serial source, test host) drive the ALU and read back a stable, registered result.

Parameters:
W, 4, data width of operands, input bus, ALU result and result register; must equal the ALU width.

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-high reset
clr  input  1  synchronous abort: return to LOAD_A, discard partial load and result
in_data  input  W  operand/opcode word
in_valid  input  1  in_data is valid this cycle
in_ready  output  1  block accepts in_data this cycle
alu_a  output  W  registered operand A to ALU input a
alu_b  output  W  registered operand B to ALU input b
alu_sel  output  1  registered opcode to ALU select (0 = add, 1 = AND)
alu_c  input  W  combinational ALU result
res_data  output  W  registered result
res_zero  output  1  res_data == 0, registered with res_data
res_valid  output  1  res_data/res_zero valid
res_ready  input  1  consumer takes result this cycle
busy  output  1  high in any state other than LOAD_A

Behaviour:
- Reset (rst high, async): state = LOAD_A; alu_a = 0, alu_b = 0, alu_sel = 0, res_data = 0, res_zero = 0, res_valid = 0, busy = 0. in_ready forced 0 while rst is high; no handshake is taken.
- Input handshake: a word transfers on a rising edge with in_valid && in_ready. Output handshake: transfers on a rising edge with res_valid && res_ready.
- in_ready = 1 only in LOAD_A, LOAD_B and LOAD_OP; otherwise 0. in_data is ignored when in_valid is low; gaps of any length are allowed.
- FSM, 5 states:
  - LOAD_A: on input handshake, alu_a <= in_data -> LOAD_B.
  - LOAD_B: on input handshake, alu_b <= in_data -> LOAD_OP.
  - LOAD_OP: on input handshake, alu_sel <= in_data[0] (bits W-1:1 ignored) -> EXEC.
  - EXEC (exactly 1 cycle): res_data <= alu_c, res_zero <= (alu_c == 0), res_valid <= 1 -> HOLD.
  - HOLD: res_valid = 1. res_data and res_zero are stable. On output handshake, res_valid <= 0 -> LOAD_A.
- Latency: opcode accepted at edge N -> res_valid high after edge N+1. Minimum period is 5 cycles per operation: 3 loads, EXEC, and 1 HOLD cycle with res_ready high.
- Arithmetic: the result is exactly the W-bit alu_c. The add wraps modulo 2^W and carry is lost (9 + 8 = 1 for W = 4).
- alu_a, alu_b and alu_sel keep their values after the result is taken, until overwritten by the next load.
- clr (synchronous, checked before any handshake in the same cycle): state <= LOAD_A, res_valid <= 0. Operand registers are unchanged. An input or output handshake coincident with clr is discarded.
- rst mid-operation (any state): immediate return to reset values; a pending result is lost.
- Back-pressure: with res_ready held low, the block stays in HOLD indefinitely with in_ready = 0.

Decomposition:
- Shared package: state encoding constants (LOAD_A, LOAD_B, LOAD_OP, EXEC, HOLD) and opcode constants OP_ADD = 1'b0, OP_AND = 1'b1. The ALU and the bench use the same opcode constants.
- No sub-module: FSM and registers stay in one module. The ALU is instantiated beside it at the integration top; it is not embedded in this block.

Test Plan:
- W=4, load A = 4'h9, B = 4'h8, op = 4'h0, res_ready = 1 -> after EXEC: res_data = 4'h1, res_zero = 0, res_valid for 1 cycle, then in_ready = 1 again.
- A = 4'hC, B = 4'h3, op = 4'hF (bit0 = 1, AND) -> res_data = 4'h0, res_zero = 1. Then op = 4'hE with the same operands -> add, res_data = 4'hF.
- in_valid toggled with random 0–3 cycle gaps, and res_ready low for 6 cycles -> res_data stable throughout, in_ready = 0 throughout HOLD, result taken on the first res_ready cycle.
- clr asserted in LOAD_OP with in_valid = 1 -> opcode not taken, state LOAD_A, busy = 0, no res_valid pulse.
- rst asserted asynchronously mid-HOLD, between clock edges -> res_valid, res_data and alu_* go to 0 immediately. After release, a fresh 3-word load produces a correct result.
- Back-to-back operations with in_valid and res_ready held high -> one result every 5 cycles, values match the reference model (A + B mod 16, A & B).
